// File: rtl/div_ctrl_pkg.sv
// Shared types and width helpers for the divider issue controller.
package div_ctrl_pkg;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DIV_LATENCY = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold DIV_LATENCY itself, not just DIV_LATENCY-1.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_arb.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o
);

  int idx;

  // Scan from farthest to nearest so the nearest match is the last write.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Shares one pipelined divider among NUM_REQ requesters with per-requester result slots.
// Optional DIV_ZERO_BYPASS_EN: zero-divisor requests complete at the accept edge without using the divider.
//
// state    | meaning
// DIV_IDLE | no op in flight; accepting the next round-robin winner
// DIV_RUN  | operands held on div_*; counting down to result capture
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  input  logic [NUM_REQ-1:0]       resp_ready_i,
  output logic [NUM_REQ*WIDTH-1:0] resp_quotient_o,
  output logic [NUM_REQ*WIDTH-1:0] resp_remainder_o,
  output logic [NUM_REQ-1:0]       resp_dz_o,
  output logic [WIDTH-1:0]         div_dividend_o,
  output logic [WIDTH-1:0]         div_divisor_o,
  input  logic [WIDTH-1:0]         div_quotient_i,
  input  logic [WIDTH-1:0]         div_remainder_i
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  div_state_e         state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    op_id_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   op_dividend_q;
  logic [WIDTH-1:0]   op_divisor_q;
  logic [NUM_REQ-1:0] slot_valid_q;
  logic [NUM_REQ-1:0] slot_dz_q;
  logic [WIDTH-1:0]   slot_quot_q [NUM_REQ];
  logic [WIDTH-1:0]   slot_rem_q  [NUM_REQ];

  logic [WIDTH-1:0]   req_a [NUM_REQ];
  logic [WIDTH-1:0]   req_b [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [WIDTH-1:0]   acc_a;
  logic [WIDTH-1:0]   acc_b;
  logic               accept;
  logic               bypass;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign req_a[g] = req_dividend_i[g*WIDTH +: WIDTH];
    assign req_b[g] = req_divisor_i[g*WIDTH +: WIDTH];
    assign resp_quotient_o[g*WIDTH +: WIDTH]  = slot_quot_q[g];
    assign resp_remainder_o[g*WIDTH +: WIDTH] = slot_rem_q[g];
  end

  // Registered slot_valid: a slot popped this cycle becomes eligible next cycle.
  assign eligible = req_valid_i & ~slot_valid_q;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i    (eligible),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (grant),
    .gnt_id_o (grant_id)
  );

  assign accept      = (state_q == DIV_IDLE) && !reset_i && (|eligible);
  assign req_ready_o = accept ? grant : '0;
  assign acc_a       = req_a[grant_id];
  assign acc_b       = req_b[grant_id];
  assign rr_ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = (acc_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= DIV_IDLE;
      rr_ptr_q      <= '0;
      op_id_q       <= '0;
      count_q       <= '0;
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      slot_valid_q  <= '0;
      slot_dz_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_quot_q[i] <= '0;
        slot_rem_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (slot_valid_q[i] && resp_ready_i[i]) slot_valid_q[i] <= 1'b0;
      end
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            rr_ptr_q <= rr_ptr_d;
            if (bypass) begin
              slot_quot_q[grant_id]  <= '1;
              slot_rem_q[grant_id]   <= acc_a;
              slot_dz_q[grant_id]    <= 1'b1;
              slot_valid_q[grant_id] <= 1'b1;
            end else begin
              op_dividend_q <= acc_a;
              op_divisor_q  <= acc_b;
              op_id_q       <= grant_id;
              count_q       <= CNT_LOAD;
              state_q       <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            // Divider already yields all-ones/dividend on zero divisor; only dz is ours.
            slot_quot_q[op_id_q]  <= div_quotient_i;
            slot_rem_q[op_id_q]   <= div_remainder_i;
            slot_dz_q[op_id_q]    <= (op_divisor_q == '0);
            slot_valid_q[op_id_q] <= 1'b1;
            state_q               <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign resp_valid_o   = slot_valid_q;
  assign resp_dz_o      = slot_dz_q;
  assign div_dividend_o = op_dividend_q;
  assign div_divisor_o  = op_divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a pipelined divider model.
module tb_div_issue_ctrl;

  localparam int W    = 32;
  localparam int N    = 4;
  localparam int L    = 8;
  localparam int PIPE = L - 1;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N-1:0]     req_valid_i, req_ready_o, resp_valid_o, resp_ready_i, resp_dz_o;
  logic [N*W-1:0]   req_dividend_i, req_divisor_i, resp_quotient_o, resp_remainder_o;
  logic [W-1:0]     div_dividend_o, div_divisor_o, div_quotient_i, div_remainder_i;

  always #5 clk_i = ~clk_i;

  div_issue_ctrl #(.WIDTH(W), .NUM_REQ(N), .DIV_LATENCY(L)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_dividend_i   (req_dividend_i),
    .req_divisor_i    (req_divisor_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_quotient_o  (resp_quotient_o),
    .resp_remainder_o (resp_remainder_o),
    .resp_dz_o        (resp_dz_o),
    .div_dividend_o   (div_dividend_o),
    .div_divisor_o    (div_divisor_o),
    .div_quotient_i   (div_quotient_i),
    .div_remainder_i  (div_remainder_i)
  );

  // Divider model: result of the operands on div_* appears PIPE edges later.
  logic [W-1:0] pq [PIPE];
  logic [W-1:0] pr [PIPE];
  initial for (int k = 0; k < PIPE; k++) begin pq[k] = '0; pr[k] = '0; end
  always @(posedge clk_i) begin
    pq[0] <= (div_divisor_o == '0) ? '1 : div_dividend_o / div_divisor_o;
    pr[0] <= (div_divisor_o == '0) ? div_dividend_o : div_dividend_o % div_divisor_o;
    for (int k = 1; k < PIPE; k++) begin
      pq[k] <= pq[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign div_quotient_i  = pq[PIPE-1];
  assign div_remainder_i = pr[PIPE-1];

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t       sb [N][$];
  int         gnt_log[$];
  int         acc_log[$];
  int         acc_cyc [N];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_acc   = 0;
  logic [N-1:0] prev_rv = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor: push expectations on accept, check latency on rise and data on pop.
  always @(negedge clk_i) begin
    logic [W-1:0] a, b;
    exp_t e;
    if (reset_i) begin
      for (int i = 0; i < N; i++) sb[i].delete();
      prev_rv = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_ready_o[i]) begin
          a = req_dividend_i[i*W +: W];
          b = req_divisor_i[i*W +: W];
          e.q  = (b == '0) ? '1 : a / b;
          e.r  = (b == '0) ? a : a % b;
          e.dz = (b == '0);
`ifdef DIV_ZERO_BYPASS_EN
          e.lat = (b == '0) ? 1 : L + 1;
`else
          e.lat = L + 1;
`endif
          sb[i].push_back(e);
          gnt_log.push_back(i);
          acc_log.push_back(cyc);
          acc_cyc[i] = cyc;
          n_acc++;
        end
        if (resp_valid_o[i] && !prev_rv[i]) begin
          if (sb[i].size() == 0) check($sformatf("rv_unexpected%0d", i), 64'(resp_valid_o[i]), 0);
          else check($sformatf("latency%0d", i), 64'(cyc - acc_cyc[i]), 64'(sb[i][0].lat));
        end
        if (resp_valid_o[i] && resp_ready_i[i] && sb[i].size() != 0) begin
          e = sb[i].pop_front();
          check($sformatf("resp_q%0d", i), 64'(resp_quotient_o[i*W +: W]), 64'(e.q));
          check($sformatf("resp_r%0d", i), 64'(resp_remainder_o[i*W +: W]), 64'(e.r));
          check($sformatf("resp_dz%0d", i), 64'(resp_dz_o[i]), 64'(e.dz));
        end
      end
      prev_rv = resp_valid_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend_i[i*W +: W] = a;
    req_divisor_i[i*W +: W]  = b;
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    req_valid_i = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    gnt_log.delete();
    acc_log.delete();
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int k = 0; k < 200; k++) begin
      if (n_acc >= target) return;
      tick();
    end
    check({tag, "_timeout"}, 64'(n_acc), 64'(target));
  endtask

  function automatic int sb_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += sb[i].size();
    return t;
  endfunction

  task automatic drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (sb_total() == 0) return;
      tick();
    end
    check({tag, "_drain"}, 64'(sb_total()), 0);
  endtask

  initial begin
    int base;
    logic [W-1:0] prev_div;
    logic rv_seen;

    reset_i        = 1'b1;
    req_valid_i    = '1;
    resp_ready_i   = '1;
    req_dividend_i = '0;
    req_divisor_i  = '0;
    repeat (3) tick();
    check("rst_req_ready", 64'(req_ready_o), 0);
    check("rst_resp_valid", 64'(resp_valid_o), 0);
    check("rst_div_dividend", 64'(div_dividend_o), 0);
    check("rst_div_divisor", 64'(div_divisor_o), 0);
    check("rst_resp_q", 64'(resp_quotient_o[W-1:0]), 0);
    check("rst_resp_dz", 64'(resp_dz_o), 0);
    req_valid_i = '0;
    reset_i     = 1'b0;
    gnt_log.delete();
    acc_log.delete();

    // single op 100/7
    set_op(0, 100, 7);
    req_valid_i = 4'b0001;
    wait_acc(1, "single");
    req_valid_i = '0;
    check("single_gnt", 64'(gnt_log[0]), 0);
    drain("single");

    // round robin from reset, all requesters busy
    do_reset();
    base = n_acc;
    set_op(0, 1000, 3);
    set_op(1, 77, 5);
    set_op(2, 65535, 256);
    set_op(3, 12345, 1);
    req_valid_i = 4'b1111;
    wait_acc(base + 5, "rr");
    req_valid_i = '0;
    drain("rr");
    check("rr_count", 64'(gnt_log.size()), 5);
    if (gnt_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), 64'(gnt_log[k]), 64'(k % 4));
      for (int k = 1; k < 5; k++) check($sformatf("rr_gap%0d", k), 64'(acc_log[k] - acc_log[k-1]), 64'(L + 1));
    end

    // slot backpressure on requester 1
    gnt_log.delete();
    base = n_acc;
    resp_ready_i = 4'b1101;
    set_op(1, 500, 6);
    req_valid_i = 4'b0010;
    wait_acc(base + 1, "bp_first");
    set_op(1, 81, 9);
    set_op(2, 300, 7);
    req_valid_i = 4'b0110;
    wait_acc(base + 2, "bp_req2");
    req_valid_i = 4'b0010;
    repeat (25) tick();
    check("bp_hold_acc", 64'(n_acc - base), 2);
    check("bp_slot1_full", 64'(resp_valid_o[1]), 1);
    check("bp_order", 64'(gnt_log[1]), 2);
    resp_ready_i[1] = 1'b1;
    tick();
    resp_ready_i[1] = 1'b0;
    wait_acc(base + 3, "bp_regrant");
    req_valid_i = '0;
    check("bp_regrant_id", 64'(gnt_log[2]), 1);
    resp_ready_i = '1;
    drain("bp");

    // divide by zero
    base = n_acc;
    prev_div = div_divisor_o;
    set_op(3, 55, 0);
    req_valid_i = 4'b1000;
    wait_acc(base + 1, "dz");
    req_valid_i = '0;
`ifdef DIV_ZERO_BYPASS_EN
    check("dz_div_hold", 64'(div_divisor_o), 64'(prev_div));
`else
    check("dz_div_drive", 64'(div_divisor_o), 0);
`endif
    drain("dz");

    // operand hold after accept
    base = n_acc;
    set_op(2, 200, 9);
    req_valid_i = 4'b0100;
    wait_acc(base + 1, "hold");
    set_op(2, 999, 3);
    req_valid_i = '0;
    repeat (4) tick();
    check("hold_run", 64'(div_dividend_o), 200);
    drain("hold");
    repeat (3) tick();
    check("hold_idle_a", 64'(div_dividend_o), 200);
    check("hold_idle_b", 64'(div_divisor_o), 9);

    // reset in the middle of an op granted to requester 1
    base = n_acc;
    set_op(1, 1234, 5);
    req_valid_i = 4'b0010;
    wait_acc(base + 1, "rst_mid");
    req_valid_i = '0;
    repeat (4) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rv_seen = rv_seen | (|resp_valid_o);
      tick();
    end
    check("rst_no_resp", 64'(rv_seen), 0);
    gnt_log.delete();
    base = n_acc;
    set_op(0, 10, 2);
    set_op(2, 20, 4);
    req_valid_i = 4'b0101;
    wait_acc(base + 1, "rst_ptr");
    req_valid_i = '0;
    check("rst_ptr_gnt", 64'(gnt_log[0]), 0);
    drain("rst_ptr");

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
